// File: rtl/axi_master128_if.sv
// axi_master128_if: AXI bus between axi_master128 (m0 side) and the on-chip
// SRAM slave (*_s0 side). 128-bit data, 40-bit address, 8-bit ids.
//   master modport: drives AW/W/AR address+data, bready, rready.
//   slave  modport: drives a*ready, wready, B and R channels.
interface axi_master128_if;
  // write address
  logic [39:0]  awaddr_m0;
  logic [7:0]   awlen_m0;
  logic [7:0]   awid_m0;
  logic [2:0]   awsize_m0;
  logic [1:0]   awburst_m0;
  logic [3:0]   awcache_m0;
  logic [2:0]   awprot_m0;
  logic         awvalid_m0;
  logic         awready_m0;
  // write data
  logic [127:0] wdata_m0;
  logic [15:0]  wstrb_m0;
  logic [7:0]   wid_m0;
  logic         wlast_m0;
  logic         wvalid_m0;
  logic         wready_m0;
  // write response
  logic [7:0]   bid_m0;
  logic [1:0]   bresp_m0;
  logic         bvalid_m0;
  logic         bready_m0;
  // read address
  logic [39:0]  araddr_m0;
  logic [7:0]   arlen_m0;
  logic [7:0]   arid_m0;
  logic [2:0]   arsize_m0;
  logic [1:0]   arburst_m0;
  logic [3:0]   arcache_m0;
  logic [2:0]   arprot_m0;
  logic         arvalid_m0;
  logic         arready_m0;
  // read data
  logic [127:0] rdata_m0;
  logic [7:0]   rid_m0;
  logic [1:0]   rresp_m0;
  logic         rlast_m0;
  logic         rvalid_m0;
  logic         rready_m0;

  modport master (
    output awaddr_m0, awlen_m0, awid_m0, awsize_m0, awburst_m0, awcache_m0,
           awprot_m0, awvalid_m0,
    input  awready_m0,
    output wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0,
    input  wready_m0,
    input  bid_m0, bresp_m0, bvalid_m0,
    output bready_m0,
    output araddr_m0, arlen_m0, arid_m0, arsize_m0, arburst_m0, arcache_m0,
           arprot_m0, arvalid_m0,
    input  arready_m0,
    input  rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0,
    output rready_m0
  );

  modport slave (
    input  awaddr_m0, awlen_m0, awid_m0, awsize_m0, awburst_m0, awcache_m0,
           awprot_m0, awvalid_m0,
    output awready_m0,
    input  wdata_m0, wstrb_m0, wid_m0, wlast_m0, wvalid_m0,
    output wready_m0,
    output bid_m0, bresp_m0, bvalid_m0,
    input  bready_m0,
    input  araddr_m0, arlen_m0, arid_m0, arsize_m0, arburst_m0, arcache_m0,
           arprot_m0, arvalid_m0,
    output arready_m0,
    output rdata_m0, rid_m0, rresp_m0, rlast_m0, rvalid_m0,
    input  rready_m0
  );
endinterface

// File: rtl/axi_master128.sv
// axi_master128: command-driven AXI master, one outstanding transaction.
// A single command (read/write, addr, len, id) becomes AR/R or AW/W/B traffic;
// write data streams in on wr_*, read data streams out on rd_*.
// Ports:
//   pll_core_cpuclk / pad_cpu_rst_b : clock, async active-low reset
//   cmd_*   : command handshake (cmd_ready high only while idle)
//   wr_*    : write data stream, passed through to W while in the W phase
//   rd_*    : read data stream, passed through from R while in the R phase
//   done / done_resp : one-cycle completion pulse, worst response seen
//   m0      : AXI master bus (axi_master128_if.master)
// Build option: define AXI_MST128_RCHK_EN to check rid/rlast on every R beat
// and bid on B; any mismatch reports done_resp=2'b10 for that transaction.
module axi_master128 #(
  parameter logic [3:0] AXCACHE = 4'b0011,
  parameter logic [2:0] AXPROT  = 3'b000
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic         cmd_wrap,
  input  logic [39:0]  cmd_addr,
  input  logic [7:0]   cmd_len,
  input  logic [7:0]   cmd_id,
  input  logic [127:0] wr_data,
  input  logic [15:0]  wr_strb,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic [127:0] rd_data,
  output logic         rd_valid,
  output logic         rd_last,
  input  logic         rd_ready,
  output logic         done,
  output logic [1:0]   done_resp,
  axi_master128_if.master m0
);

`ifdef AXI_MST128_RCHK_EN
  localparam bit RCHK_EN = 1'b1;
`else
  localparam bit RCHK_EN = 1'b0;
`endif

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [39:0]  addr_q, addr_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   id_q, id_d;
  logic [1:0]   burst_q, burst_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   acc_q, acc_d;
  logic         err_q, err_d;
  logic         awvalid_q, awvalid_d;
  logic         arvalid_q, arvalid_d;
  logic         bready_q, bready_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         done_q, done_d;
  logic [1:0]   done_resp_q, done_resp_d;

  logic in_r, in_w, last_beat, r_hs, w_hs;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_r      = (state_q == S_R);
  assign in_w      = (state_q == S_W);
  assign last_beat = (cnt_q == len_q);
  assign r_hs      = in_r && m0.rvalid_m0 && rd_ready;
  assign w_hs      = in_w && wr_valid && m0.wready_m0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        // Bursts are always full 16-byte beats, so the low nibble is dropped.
        addr_d  = cmd_addr & ~40'hF;
        len_d   = cmd_len;
        id_d    = cmd_id;
        // WRAP only makes sense for 2- or 4-beat bursts here; anything else
        // quietly falls back to INCR.
        burst_d = (cmd_wrap && (cmd_len == 8'd1 || cmd_len == 8'd3)) ? BURST_WRAP : BURST_INCR;
        cnt_d   = '0;
        acc_d   = '0;
        err_d   = 1'b0;
        state_d = cmd_write ? S_AW : S_AR;
      end
      S_AR: if (m0.arready_m0) state_d = S_R;
      S_R: if (r_hs) begin
        cnt_d = cnt_q + 8'd1;
        acc_d = resp_max(acc_q, m0.rresp_m0);
        if (RCHK_EN && ((m0.rid_m0 != id_q) || (m0.rlast_m0 != last_beat))) err_d = 1'b1;
        if (last_beat) state_d = S_DONE;
      end
      S_AW: if (m0.awready_m0) state_d = S_W;
      S_W: if (w_hs) begin
        cnt_d = cnt_q + 8'd1;
        if (last_beat) state_d = S_B;
      end
      S_B: if (m0.bvalid_m0) begin
        acc_d = resp_max(acc_q, m0.bresp_m0);
        if (RCHK_EN && (m0.bid_m0 != id_q)) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs follow the next state so they are flops, with no
    // combinational path from any ready back into a valid.
    awvalid_d   = (state_d == S_AW);
    arvalid_d   = (state_d == S_AR);
    bready_d    = (state_d == S_B);
    cmd_ready_d = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    done_resp_d = (state_d == S_DONE) ? (err_d ? RESP_SLVERR : acc_d) : 2'b00;
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      done_resp_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign done_resp = done_resp_q;

  // Address channels share the captured command.
  assign m0.awaddr_m0  = addr_q;
  assign m0.awlen_m0   = len_q;
  assign m0.awid_m0    = id_q;
  assign m0.awsize_m0  = 3'b100;
  assign m0.awburst_m0 = burst_q;
  assign m0.awcache_m0 = AXCACHE;
  assign m0.awprot_m0  = AXPROT;
  assign m0.awvalid_m0 = awvalid_q;

  assign m0.araddr_m0  = addr_q;
  assign m0.arlen_m0   = len_q;
  assign m0.arid_m0    = id_q;
  assign m0.arsize_m0  = 3'b100;
  assign m0.arburst_m0 = burst_q;
  assign m0.arcache_m0 = AXCACHE;
  assign m0.arprot_m0  = AXPROT;
  assign m0.arvalid_m0 = arvalid_q;

  // W is a gated pass-through of the write stream, open only after AW.
  assign m0.wdata_m0  = wr_data;
  assign m0.wstrb_m0  = wr_strb;
  assign m0.wid_m0    = id_q;
  assign m0.wlast_m0  = in_w && last_beat;
  assign m0.wvalid_m0 = in_w && wr_valid;
  assign wr_ready     = in_w && m0.wready_m0;

  assign m0.bready_m0 = bready_q;

  // R is a gated pass-through to the read stream; rd_last comes from our own
  // beat count, not from the slave.
  assign m0.rready_m0 = in_r && rd_ready;
  assign rd_valid     = in_r && m0.rvalid_m0;
  assign rd_data      = m0.rdata_m0;
  assign rd_last      = rd_valid && last_beat;

endmodule

// File: tb/tb_axi_master128.sv
module tb_axi_master128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid = 0, cmd_write = 0, cmd_wrap = 0;
  logic [39:0]  cmd_addr = '0;
  logic [7:0]   cmd_len = '0, cmd_id = '0;
  logic         cmd_ready;
  logic [127:0] wr_data = '0;
  logic [15:0]  wr_strb = '0;
  logic         wr_valid = 0, wr_ready;
  logic [127:0] rd_data;
  logic         rd_valid, rd_last;
  logic         rd_ready = 1;
  logic         done;
  logic [1:0]   done_resp;

  axi_master128_if m0_if();

  axi_master128 dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_wrap(cmd_wrap), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .m0(m0_if)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++; failures++;
    $display("FAIL %s unexpected event at %0t", nm, $time);
  endtask

  // Hand-chosen memory background so every row is distinguishable.
  function automatic logic [127:0] pat(input logic [12:0] row);
    logic [31:0] r;
    r = {19'd0, row};
    return {r ^ 32'hA5A5_0000, ~r, r + 32'h1111_1111, 32'hC0DE_0000 | r};
  endfunction

  function automatic logic [127:0] dv(input int i);
    logic [7:0] b;
    b = 8'h11 * 8'(i + 1);
    return {16{b}};
  endfunction

  // ---------------- slave model (SRAM) ----------------
  logic [127:0] mem [0:8191];
  logic [1:0]   force_bresp = 0, force_rval = 0;
  int           force_rbeat = -1;
  logic [7:0]   rid_xor = 0;
  logic [39:0]  r_addr, w_addr;
  logic [7:0]   r_len, w_len, r_id, w_id;
  logic [1:0]   r_burst, w_burst;
  int           r_beat, w_beat, nb;
  logic         rd_act;

  initial for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));

  function automatic logic [12:0] beat_row(input logic [39:0] a, input logic [7:0] len,
                                           input logic [1:0] burst, input int beat);
    logic [39:0] bnd, base, off, ad;
    if (burst == 2'b10) begin
      bnd  = ({32'd0, len} + 40'd1) << 4;
      base = a & ~(bnd - 40'd1);
      off  = (a - base + (40'(beat) << 4)) % bnd;
      ad   = base + off;
    end else ad = a + (40'(beat) << 4);
    return ad[16:4];
  endfunction

  assign m0_if.wready_m0 = 1'b1;
  always_comb nb = (m0_if.rvalid_m0 && m0_if.rready_m0) ? r_beat + 1 : r_beat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_if.arready_m0 <= 0; m0_if.awready_m0 <= 0;
      m0_if.rvalid_m0 <= 0; m0_if.rlast_m0 <= 0; m0_if.rdata_m0 <= '0;
      m0_if.rid_m0 <= 0; m0_if.rresp_m0 <= 0;
      m0_if.bvalid_m0 <= 0; m0_if.bid_m0 <= 0; m0_if.bresp_m0 <= 0;
      rd_act <= 0; r_beat <= 0; w_beat <= 0;
    end else begin
      m0_if.arready_m0 <= m0_if.arvalid_m0 && !m0_if.arready_m0;
      m0_if.awready_m0 <= m0_if.awvalid_m0 && !m0_if.awready_m0;
      if (m0_if.arvalid_m0 && m0_if.arready_m0) begin
        r_addr <= m0_if.araddr_m0; r_len <= m0_if.arlen_m0;
        r_burst <= m0_if.arburst_m0; r_id <= m0_if.arid_m0;
        r_beat <= 0; rd_act <= 1;
      end else if (rd_act) begin
        if (m0_if.rvalid_m0 && m0_if.rready_m0) r_beat <= r_beat + 1;
        if (m0_if.rvalid_m0 && !m0_if.rready_m0) begin
          // hold current beat
        end else if (nb <= int'(r_len)) begin
          m0_if.rvalid_m0 <= 1;
          m0_if.rdata_m0  <= mem[beat_row(r_addr, r_len, r_burst, nb)];
          m0_if.rlast_m0  <= (nb == int'(r_len));
          m0_if.rid_m0    <= r_id ^ rid_xor;
          m0_if.rresp_m0  <= (nb == force_rbeat) ? force_rval : 2'b00;
        end else begin
          m0_if.rvalid_m0 <= 0; m0_if.rlast_m0 <= 0; rd_act <= 0;
        end
      end
      if (m0_if.awvalid_m0 && m0_if.awready_m0) begin
        w_addr <= m0_if.awaddr_m0; w_len <= m0_if.awlen_m0;
        w_burst <= m0_if.awburst_m0; w_id <= m0_if.awid_m0; w_beat <= 0;
      end
      if (m0_if.wvalid_m0 && m0_if.wready_m0) begin
        for (int b = 0; b < 16; b++)
          if (m0_if.wstrb_m0[b])
            mem[beat_row(w_addr, w_len, w_burst, w_beat)][b*8 +: 8] <= m0_if.wdata_m0[b*8 +: 8];
        w_beat <= w_beat + 1;
        if (w_beat == int'(w_len)) begin
          m0_if.bvalid_m0 <= 1; m0_if.bid_m0 <= w_id; m0_if.bresp_m0 <= force_bresp;
        end
      end
      if (m0_if.bvalid_m0 && m0_if.bready_m0) m0_if.bvalid_m0 <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic wr; logic [39:0] addr; logic [7:0] len; logic [1:0] burst; logic [7:0] id;
  } aexp_t;
  typedef struct packed { logic [127:0] data; logic [15:0] strb; logic last; logic [7:0] id; } wexp_t;
  typedef struct packed { logic [127:0] data; logic last; } rexp_t;

  aexp_t      exp_a[$];
  wexp_t      exp_w[$];
  rexp_t      exp_r[$];
  logic [1:0] exp_done[$];

  task automatic chk_addr(input logic wr);
    aexp_t e;
    if (exp_a.size() == 0) begin unexpected(wr ? "aw_req" : "ar_req"); return; end
    e = exp_a.pop_front();
    chk("a_dir", 128'(wr), 128'(e.wr));
    chk(wr ? "awaddr" : "araddr", 128'(wr ? m0_if.awaddr_m0 : m0_if.araddr_m0), 128'(e.addr));
    chk(wr ? "awlen" : "arlen", 128'(wr ? m0_if.awlen_m0 : m0_if.arlen_m0), 128'(e.len));
    chk(wr ? "awburst" : "arburst", 128'(wr ? m0_if.awburst_m0 : m0_if.arburst_m0), 128'(e.burst));
    chk(wr ? "awid" : "arid", 128'(wr ? m0_if.awid_m0 : m0_if.arid_m0), 128'(e.id));
    chk("asize", 128'(wr ? m0_if.awsize_m0 : m0_if.arsize_m0), 128'(3'b100));
    chk("acache", 128'(wr ? m0_if.awcache_m0 : m0_if.arcache_m0), 128'(4'b0011));
    chk("aprot", 128'(wr ? m0_if.awprot_m0 : m0_if.arprot_m0), 128'(3'b000));
  endtask

  always @(negedge clk) begin
    wexp_t we;
    rexp_t re;
    logic [1:0] de;
    if (rst_n) begin
      if (m0_if.awvalid_m0 && m0_if.awready_m0) chk_addr(1'b1);
      if (m0_if.arvalid_m0 && m0_if.arready_m0) chk_addr(1'b0);
      if (m0_if.wvalid_m0 && m0_if.wready_m0) begin
        if (exp_w.size() == 0) unexpected("w_beat");
        else begin
          we = exp_w.pop_front();
          chk("wdata", m0_if.wdata_m0, we.data);
          chk("wstrb", 128'(m0_if.wstrb_m0), 128'(we.strb));
          chk("wlast", 128'(m0_if.wlast_m0), 128'(we.last));
          chk("wid", 128'(m0_if.wid_m0), 128'(we.id));
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_r.size() == 0) unexpected("rd_beat");
        else begin
          re = exp_r.pop_front();
          chk("rd_data", rd_data, re.data);
          chk("rd_last", 128'(rd_last), 128'(re.last));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          de = exp_done.pop_front();
          chk("done_resp", 128'(done_resp), 128'(de));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_a(input logic wr, input logic [39:0] a, input logic [7:0] l,
                        input logic [1:0] b, input logic [7:0] id);
    aexp_t e;
    e.wr = wr; e.addr = a; e.len = l; e.burst = b; e.id = id;
    exp_a.push_back(e);
  endtask

  task automatic push_w(input logic [127:0] d, input logic [15:0] s, input logic l, input logic [7:0] id);
    wexp_t e;
    e.data = d; e.strb = s; e.last = l; e.id = id;
    exp_w.push_back(e);
  endtask

  task automatic push_r(input logic [127:0] d, input logic l);
    rexp_t e;
    e.data = d; e.last = l;
    exp_r.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic wr, input logic wrap, input logic [39:0] a,
                       input logic [7:0] l, input logic [7:0] id);
    int n = 0;
    cmd_write = wr; cmd_wrap = wrap; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) unexpected("cmd_ready_timeout");
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] s);
    int n = 0;
    wr_valid = 1; wr_data = d; wr_strb = s;
    @(negedge clk);
    while (!wr_ready && n < 200) begin @(negedge clk); n++; end
    if (!wr_ready) unexpected("wr_ready_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (exp_done.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    #1;
    if (exp_done.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s done_timeout pending=%0d", nm, exp_done.size());
      exp_done.delete(); exp_r.delete(); exp_w.delete(); exp_a.delete();
    end
  endtask

  logic [127:0] tmp;

  initial begin
    // reset state
    #12;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_awvalid", 128'(m0_if.awvalid_m0), 128'(0));
    chk("rst_arvalid", 128'(m0_if.arvalid_m0), 128'(0));
    chk("rst_wvalid", 128'(m0_if.wvalid_m0), 128'(0));
    chk("rst_bready", 128'(m0_if.bready_m0), 128'(0));
    chk("rst_rready", 128'(m0_if.rready_m0), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_done_resp", 128'(done_resp), 128'(0));
    chk("rst_wr_ready", 128'(wr_ready), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    @(posedge clk); #3; rst_n = 1;
    @(posedge clk); #1;

    // write 0x1000 len 3 INCR, then read it back
    push_a(1, 40'h1000, 8'd3, 2'b01, 8'h21);
    for (int i = 0; i < 4; i++) push_w(dv(i), 16'hFFFF, i == 3, 8'h21);
    exp_done.push_back(2'b00);
    issue(1, 0, 40'h1000, 8'd3, 8'h21);
    for (int i = 0; i < 4; i++) send_beat(dv(i), 16'hFFFF);
    wr_valid = 0;
    wait_done("wr_incr4");

    push_a(0, 40'h1000, 8'd3, 2'b01, 8'h22);
    for (int i = 0; i < 4; i++) push_r(dv(i), i == 3);
    exp_done.push_back(2'b00);
    issue(0, 0, 40'h1000, 8'd3, 8'h22);
    wait_done("rd_incr4");

    // wrap read at 0x30: rows 3,0,1,2
    push_a(0, 40'h30, 8'd3, 2'b10, 8'h31);
    push_r(pat(13'h3), 0); push_r(pat(13'h0), 0); push_r(pat(13'h1), 0); push_r(pat(13'h2), 1);
    exp_done.push_back(2'b00);
    issue(0, 1, 40'h30, 8'd3, 8'h31);
    wait_done("rd_wrap4");

    // wrap len 1 at 0x10: rows 1,0
    push_a(0, 40'h10, 8'd1, 2'b10, 8'h33);
    push_r(pat(13'h1), 0); push_r(pat(13'h0), 1);
    exp_done.push_back(2'b00);
    issue(0, 1, 40'h10, 8'd1, 8'h33);
    wait_done("rd_wrap2");

    // wrap requested with len 2 -> INCR; unaligned address masked
    push_a(0, 40'h2000, 8'd2, 2'b01, 8'h32);
    for (int i = 0; i < 3; i++) push_r(pat(13'h200 + 13'(i)), i == 2);
    exp_done.push_back(2'b00);
    issue(0, 1, 40'h2007, 8'd2, 8'h32);
    wait_done("rd_wrap_len2");

    // single-beat partial strobe write, then readback
    push_a(1, 40'h500, 8'd0, 2'b01, 8'h41);
    push_w({16{8'h55}}, 16'h000F, 1, 8'h41);
    exp_done.push_back(2'b00);
    issue(1, 0, 40'h500, 8'd0, 8'h41);
    send_beat({16{8'h55}}, 16'h000F);
    wr_valid = 0;
    wait_done("wr_strb");
    tmp = pat(13'h50);
    push_a(0, 40'h500, 8'd0, 2'b01, 8'h42);
    push_r({tmp[127:32], 32'h5555_5555}, 1);
    exp_done.push_back(2'b00);
    issue(0, 0, 40'h500, 8'd0, 8'h42);
    wait_done("rd_strb");

    // len 7 with rd_ready toggling every cycle
    push_a(0, 40'h1000, 8'd7, 2'b01, 8'h51);
    for (int i = 0; i < 4; i++) push_r(dv(i), 0);
    for (int i = 4; i < 8; i++) push_r(pat(13'h100 + 13'(i)), i == 7);
    exp_done.push_back(2'b00);
    issue(0, 0, 40'h1000, 8'd7, 8'h51);
    for (int n = 0; n < 400 && exp_done.size() != 0; n++) begin
      @(posedge clk); #1; rd_ready = ~rd_ready;
    end
    rd_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    wait_done("rd_toggle");

    // len 255 (wrap requested -> INCR), 256 beats
    push_a(0, 40'h10000, 8'd255, 2'b01, 8'h61);
    for (int i = 0; i < 256; i++) push_r(pat(13'h1000 + 13'(i)), i == 255);
    exp_done.push_back(2'b00);
    issue(0, 1, 40'h10000, 8'd255, 8'h61);
    wait_done("rd_len255");

    // slave error responses accumulate as a maximum
    force_rbeat = 1; force_rval = 2'b01;
    push_a(0, 40'h600, 8'd3, 2'b01, 8'h71);
    for (int i = 0; i < 4; i++) push_r(pat(13'h60 + 13'(i)), i == 3);
    exp_done.push_back(2'b01);
    issue(0, 0, 40'h600, 8'd3, 8'h71);
    wait_done("rd_exokay");
    force_rbeat = -1; force_rval = 0;

    force_bresp = 2'b11;
    push_a(1, 40'h700, 8'd1, 2'b01, 8'h72);
    push_w(dv(5), 16'hFFFF, 0, 8'h72); push_w(dv(6), 16'hFFFF, 1, 8'h72);
    exp_done.push_back(2'b11);
    issue(1, 0, 40'h700, 8'd1, 8'h72);
    send_beat(dv(5), 16'hFFFF); send_beat(dv(6), 16'hFFFF);
    wr_valid = 0;
    wait_done("wr_decerr");
    force_bresp = 0;

    // wrong rid from slave
    rid_xor = 8'h01;
    push_a(0, 40'h800, 8'd1, 2'b01, 8'h80);
    push_r(pat(13'h80), 0); push_r(pat(13'h81), 1);
`ifdef AXI_MST128_RCHK_EN
    exp_done.push_back(2'b10);
`else
    exp_done.push_back(2'b00);
`endif
    issue(0, 0, 40'h800, 8'd1, 8'h80);
    wait_done("rd_rid_mismatch");
    rid_xor = 0;

    // reset during W beat 2 of a len-3 write
    push_a(1, 40'h3000, 8'd3, 2'b01, 8'h91);
    push_w(dv(0), 16'hFFFF, 0, 8'h91); push_w(dv(1), 16'hFFFF, 0, 8'h91);
    issue(1, 0, 40'h3000, 8'd3, 8'h91);
    send_beat(dv(0), 16'hFFFF); send_beat(dv(1), 16'hFFFF);
    wr_valid = 1; wr_data = dv(2); wr_strb = 16'hFFFF;
    #2; rst_n = 0;
    exp_a.delete(); exp_w.delete(); exp_r.delete(); exp_done.delete();
    @(negedge clk);
    chk("mid_rst_awvalid", 128'(m0_if.awvalid_m0), 128'(0));
    chk("mid_rst_wvalid", 128'(m0_if.wvalid_m0), 128'(0));
    chk("mid_rst_wr_ready", 128'(wr_ready), 128'(0));
    chk("mid_rst_bready", 128'(m0_if.bready_m0), 128'(0));
    chk("mid_rst_arvalid", 128'(m0_if.arvalid_m0), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    wr_valid = 0;
    @(posedge clk); #3; rst_n = 1;
    @(posedge clk); #1;

    // operation resumes after reset
    push_a(0, 40'h1000, 8'd0, 2'b01, 8'hA1);
    push_r(dv(0), 1);
    exp_done.push_back(2'b00);
    issue(0, 0, 40'h1000, 8'd0, 8'hA1);
    wait_done("rd_after_reset");

    repeat (5) @(posedge clk);
    chk("leftover_a", 128'(exp_a.size()), 128'(0));
    chk("leftover_w", 128'(exp_w.size()), 128'(0));
    chk("leftover_r", 128'(exp_r.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
